// File: rtl/subsys_lifecycle_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | subsys_lifecycle_seq: ordered N-channel subsystem bring-up and teardown.   |
// | Optional ack timeout enabled by macro SUBSYS_LIFECYCLE_SEQ_TMO_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module subsys_lifecycle_seq #(
   parameter int unsigned      N_SUB   = 8,
   parameter int unsigned      IDX_W   = $clog2(N_SUB),
   parameter int unsigned      TMO_W   = 16,
   parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(1000)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             stop_i,
   output logic [N_SUB-1:0] init_req_o,
   input  logic [N_SUB-1:0] init_ack_i,
   input  logic [N_SUB-1:0] init_err_i,
   output logic [N_SUB-1:0] down_req_o,
   input  logic [N_SUB-1:0] down_ack_i,
   output logic [N_SUB-1:0] up_mask_o,
   output logic             busy_o,
   output logic             up_o,
   output logic             done_o,
   output logic             err_o,
   output logic [IDX_W-1:0] err_idx_o,
   output logic             err_tmo_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_IGAP = 3'd2,
      S_RUN  = 3'd3,
      S_SHUT = 3'd4,
      S_SGAP = 3'd5
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic             r_stop_pend;

   logic             w_ack, w_ierr, w_dack, w_tmo, w_last;
   logic [N_SUB-1:0] w_onehot, w_msb_onehot;
   logic [IDX_W-1:0] w_msb;

   function automatic logic [IDX_W-1:0] f_msb(input logic [N_SUB-1:0] m);
      f_msb = '0;
      for (int i = 0; i < N_SUB; i++) begin
         if (m[i]) f_msb = IDX_W'(i);
      end
   endfunction

   assign w_ack        = (r_state == S_INIT) && init_ack_i[r_idx];
   assign w_ierr       = (r_state == S_INIT) && init_err_i[r_idx];
   assign w_dack       = (r_state == S_SHUT) && down_ack_i[r_idx];
   assign w_last       = (r_idx == IDX_W'(N_SUB - 1));
   assign w_onehot     = N_SUB'(1) << r_idx;
   assign w_msb        = f_msb(up_mask_o);
   assign w_msb_onehot = N_SUB'(1) << w_msb;

   assign busy_o = (r_state == S_INIT) || (r_state == S_IGAP) ||
                   (r_state == S_SHUT) || (r_state == S_SGAP);
   assign up_o   = (r_state == S_RUN);

`ifdef SUBSYS_LIFECYCLE_SEQ_TMO_EN
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_hs;

   // A request is always high while in INIT or SHUT, so the state alone marks a live handshake.
   assign w_hs  = (r_state == S_INIT) || (r_state == S_SHUT);
   assign w_tmo = w_hs && (r_tmo_cnt == TMO_CYC - TMO_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
      end else if (w_hs && !(w_ack || w_ierr || w_dack || w_tmo)) begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
         r_tmo_cnt <= '0;
      end
   end
`else
   logic [TMO_W-1:0] w_unused_tmo_cyc;

   assign w_unused_tmo_cyc = TMO_CYC;
   assign w_tmo            = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_stop_pend <= 1'b0;
         init_req_o  <= '0;
         down_req_o  <= '0;
         up_mask_o   <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         err_idx_o   <= '0;
         err_tmo_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_state    <= S_INIT;
                  r_idx      <= '0;
                  init_req_o <= N_SUB'(1);
                  err_o      <= 1'b0;
                  err_idx_o  <= '0;
                  err_tmo_o  <= 1'b0;
               end
            end
            S_INIT: begin
               if (stop_i) r_stop_pend <= 1'b1;
               if (w_ierr || w_tmo) begin
                  init_req_o <= '0;
                  if (!err_o) begin
                     err_o     <= 1'b1;
                     err_idx_o <= r_idx;
                     err_tmo_o <= !w_ierr;
                  end
                  // Roll back whatever already came up; nothing up means straight to IDLE.
                  if (|up_mask_o) begin
                     r_state    <= S_SHUT;
                     r_idx      <= w_msb;
                     down_req_o <= w_msb_onehot;
                  end else begin
                     r_state     <= S_IDLE;
                     done_o      <= 1'b1;
                     r_stop_pend <= 1'b0;
                  end
               end else if (w_ack) begin
                  init_req_o <= '0;
                  up_mask_o  <= up_mask_o | w_onehot;
                  if (w_last && !(r_stop_pend || stop_i)) begin
                     r_state <= S_RUN;
                     done_o  <= 1'b1;
                  end else begin
                     r_state <= S_IGAP;
                  end
               end
            end
            S_IGAP: begin
               if (r_stop_pend || stop_i) begin
                  r_stop_pend <= 1'b1;
                  r_state     <= S_SHUT;
                  r_idx       <= w_msb;
                  down_req_o  <= w_msb_onehot;
               end else begin
                  r_state    <= S_INIT;
                  r_idx      <= r_idx + IDX_W'(1);
                  init_req_o <= w_onehot << 1;
               end
            end
            S_RUN: begin
               if (stop_i) begin
                  r_state    <= S_SHUT;
                  r_idx      <= w_msb;
                  down_req_o <= w_msb_onehot;
               end
            end
            S_SHUT: begin
               // A stuck subsystem is dropped from the mask so teardown can still finish.
               if (w_dack || w_tmo) begin
                  down_req_o <= '0;
                  up_mask_o  <= up_mask_o & ~w_onehot;
                  r_state    <= S_SGAP;
                  if (!w_dack && !err_o) begin
                     err_o     <= 1'b1;
                     err_idx_o <= r_idx;
                     err_tmo_o <= 1'b1;
                  end
               end
            end
            S_SGAP: begin
               if (up_mask_o == '0) begin
                  r_state     <= S_IDLE;
                  done_o      <= 1'b1;
                  r_stop_pend <= 1'b0;
               end else begin
                  r_state    <= S_SHUT;
                  r_idx      <= w_msb;
                  down_req_o <= w_msb_onehot;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_subsys_lifecycle_seq.sv
`default_nettype none
// Scoreboard bench for subsys_lifecycle_seq (N_SUB=4); timeout scenario only
// when SUBSYS_LIFECYCLE_SEQ_TMO_EN is defined.
module tb_subsys_lifecycle_seq;
   localparam int N = 4;
   localparam int EV_DONE = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0, stop_i = 1'b0;
   logic [N-1:0] init_req_o, init_ack_i = '0, init_err_i = '0;
   logic [N-1:0] down_req_o, down_ack_i = '0, up_mask_o;
   logic         busy_o, up_o, done_o, err_o, err_tmo_o;
   logic [1:0]   err_idx_o;

   logic [N-1:0] err_mask = '0, hang_mask = '0;
   int           total = 0, bad = 0;
   int           evq[$];
   logic [N-1:0] maskq[$];

   subsys_lifecycle_seq #(.N_SUB(N), .IDX_W(2), .TMO_W(16), .TMO_CYC(16'd10)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
      .init_req_o(init_req_o), .init_ack_i(init_ack_i), .init_err_i(init_err_i),
      .down_req_o(down_req_o), .down_ack_i(down_ack_i), .up_mask_o(up_mask_o),
      .busy_o(busy_o), .up_o(up_o), .done_o(done_o), .err_o(err_o),
      .err_idx_o(err_idx_o), .err_tmo_o(err_tmo_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int tb_msb(input logic [N-1:0] v);
      int r = 0;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Subsystem model: answers one cycle after seeing a request.
   always @(posedge clk) begin
      #1;
      init_ack_i = init_req_o & ~err_mask & ~hang_mask;
      init_err_i = init_req_o & err_mask;
      down_ack_i = down_req_o;
   end

   task automatic got_ev(input int ev);
      if (evq.size() == 0) chk("unexpected_event", ev, 32'hFFFF_FFFF);
      else chk("event_order", ev, evq.pop_front());
   endtask

   // Output monitor: turns request edges, done pulses and mask changes into scoreboard pops.
   logic [N-1:0] prev_i = '0, prev_d = '0, prev_m = '0;
   always @(negedge clk) begin
      if (init_req_o != '0 && init_req_o != prev_i) begin
         chk("init_gap", prev_i, 0);
         chk("init_onehot", $countones(init_req_o), 1);
         got_ev(tb_msb(init_req_o));
      end
      if (down_req_o != '0 && down_req_o != prev_d) begin
         chk("down_gap", prev_d, 0);
         chk("down_onehot", $countones(down_req_o), 1);
         got_ev(16 + tb_msb(down_req_o));
      end
      if (done_o) got_ev(EV_DONE);
      if (up_mask_o != prev_m) begin
         if (maskq.size() == 0) chk("unexpected_mask", up_mask_o, 32'hFFFF_FFFF);
         else chk("mask_step", up_mask_o, maskq.pop_front());
      end
      prev_i = init_req_o;
      prev_d = down_req_o;
      prev_m = up_mask_o;
   end

   task automatic push_init(input int n);
      for (int i = 0; i < n; i++) evq.push_back(i);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic pulse_stop();
      stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((evq.size() != 0 || maskq.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain", evq.size() + maskq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {init_req_o, down_req_o, up_mask_o, busy_o, up_o, done_o,
                            err_o, err_idx_o, err_tmo_o}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Bring-up in order with latency 2*N
      push_init(N); evq.push_back(EV_DONE);
      maskq.push_back(4'b0001); maskq.push_back(4'b0011);
      maskq.push_back(4'b0111); maskq.push_back(4'b1111);
      start_i = 1'b1;
      n = 0;
      while (n < 50) begin
         @(posedge clk); n++;
         @(negedge clk); start_i = 1'b0;
         if (up_o) break;
      end
      chk("bringup_latency", n, 2 * N);
      drain();
      chk("run_up", {up_o, busy_o}, 2'b10);
      chk("run_mask", up_mask_o, 4'b1111);

      // Reverse teardown
      for (int i = N - 1; i >= 0; i--) evq.push_back(16 + i);
      evq.push_back(EV_DONE);
      maskq.push_back(4'b0111); maskq.push_back(4'b0011);
      maskq.push_back(4'b0001); maskq.push_back(4'b0000);
      pulse_stop();
      drain();
      chk("idle_after_stop", {up_o, busy_o, err_o}, 0);

      // Init error on subsystem 2 rolls back 1 then 0
      err_mask = 4'b0100;
      push_init(3); evq.push_back(17); evq.push_back(16); evq.push_back(EV_DONE);
      maskq.push_back(4'b0001); maskq.push_back(4'b0011);
      maskq.push_back(4'b0001); maskq.push_back(4'b0000);
      pulse_start();
      drain();
      chk("err_flags", {err_o, err_idx_o, err_tmo_o}, {1'b1, 2'd2, 1'b0});
      chk("idle_after_err", {up_o, busy_o}, 0);
      err_mask = '0;

      // Next start clears the sticky error
      push_init(N); evq.push_back(EV_DONE);
      maskq.push_back(4'b0001); maskq.push_back(4'b0011);
      maskq.push_back(4'b0111); maskq.push_back(4'b1111);
      pulse_start();
      chk("err_cleared", err_o, 0);
      drain();

      // Async reset in the middle of teardown
      evq.push_back(19); evq.push_back(18);
      maskq.push_back(4'b0111);
      pulse_stop();
      n = 0;
      while (down_req_o != 4'b0100 && n < 50) begin
         @(negedge clk); n++;
      end
      chk("reach_down2", down_req_o, 4'b0100);
      maskq.push_back(4'b0000);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {init_req_o, down_req_o, up_mask_o, busy_o, up_o, done_o,
                                  err_o, err_idx_o, err_tmo_o}, 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      drain();

      // Stop deferred while subsystem 1 is still initialising
      hang_mask = 4'b0010;
      push_init(2); evq.push_back(17); evq.push_back(16); evq.push_back(EV_DONE);
      maskq.push_back(4'b0001); maskq.push_back(4'b0011);
      maskq.push_back(4'b0001); maskq.push_back(4'b0000);
      pulse_start();
      n = 0;
      while (init_req_o != 4'b0010 && n < 50) begin
         @(negedge clk); n++;
      end
      chk("reach_init1", init_req_o, 4'b0010);
      stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      hang_mask = '0;
      drain();
      chk("idle_after_defer", {up_o, busy_o, err_o}, 0);

`ifdef SUBSYS_LIFECYCLE_SEQ_TMO_EN
      // Subsystem 1 never answers: request held exactly TMO_CYC cycles
      hang_mask = 4'b0010;
      push_init(2); evq.push_back(16); evq.push_back(EV_DONE);
      maskq.push_back(4'b0001); maskq.push_back(4'b0000);
      pulse_start();
      n = 0;
      while (init_req_o != 4'b0010 && n < 50) begin
         @(negedge clk); n++;
      end
      n = 0;
      while (init_req_o == 4'b0010 && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_req_cycles", n, 10);
      drain();
      chk("tmo_flags", {err_o, err_idx_o, err_tmo_o}, {1'b1, 2'd1, 1'b1});
      hang_mask = '0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/subsys_lifecycle_seq.md
Name: subsys_lifecycle_seq

Overview:
- Parametrised sequencer that brings up N_SUB subsystems in ascending index order, one at a time, using a per-subsystem req/ack handshake.
- Tears them down in reverse order on a stop request or on an init failure; only subsystems that actually came up are torn down.
- Sits between the top-level control FSM and the subsystem blocks (window, gfx, assets, audio, input, ...).
- Replaces the fixed-order, fixed-count bring-up with a generic N-channel version that adds error/timeout handling and abort-with-rollback.

Parameters:
- N_SUB, 8, number of managed subsystems (2..32).
- IDX_W, $clog2(N_SUB), width of index outputs.
- TMO_W, 16, timeout counter width.
- TMO_CYC, 16'd1000, cycles to wait for ack before declaring timeout (1..2^TMO_W-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle pulse; begin bring-up; honoured only in IDLE.
- stop_i  in  1  single-cycle pulse; begin teardown; honoured in INIT (deferred) and RUN.
- init_req_o  out  N_SUB  per-subsystem init request; at most one bit high.
- init_ack_i  in  N_SUB  init success acknowledge.
- init_err_i  in  N_SUB  init failure acknowledge.
- down_req_o  out  N_SUB  per-subsystem shutdown request; at most one bit high.
- down_ack_i  in  N_SUB  shutdown acknowledge.
- up_mask_o  out  N_SUB  subsystems currently up.
- busy_o  out  1  high in INIT, GAP, SHUT.
- up_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse when init completes or teardown completes.
- err_o  out  1  sticky error flag; cleared by the next accepted start_i.
- err_idx_o  out  IDX_W  index of the first failing subsystem; valid while err_o=1.
- err_tmo_o  out  1  first error was a timeout, not init_err_i.

Behaviour:
- Reset: all outputs 0; state IDLE; idx 0; stop_pend 0; timeout counter 0.
- States: IDLE, INIT, IGAP, RUN, SHUT, SGAP.
- IDLE + start_i:
  - Next edge: state INIT, idx=0, init_req_o[0]=1.
  - Clears err_o, err_idx_o and err_tmo_o.
- INIT, init_ack_i[idx] sampled high:
  - Same edge: req low, up_mask_o[idx]=1, state IGAP.
  - If idx==N_SUB-1: go to RUN instead of IGAP, with done_o=1 for one cycle.
- IGAP: one cycle with all req low; then idx+1, INIT, next req high. Latency from start_i to RUN with zero-delay acks is 2*N_SUB cycles.
- INIT, init_err_i[idx] sampled high (err takes priority over a simultaneous ack):
  - Req low; err_o=1; err_idx_o=idx; err_tmo_o=0.
  - If up_mask_o is nonzero: go to SHUT at the highest set bit. Otherwise: go to IDLE with done_o=1.
- Timeout: counter counts cycles in INIT/SHUT with req high, and clears when a req goes high. When the count reaches TMO_CYC:
  - In INIT: treated as init_err_i, with err_tmo_o=1.
  - In SHUT: req is dropped, the up_mask bit is cleared, and teardown continues (best effort).
  - In both cases, err_o/err_idx_o/err_tmo_o are set only if err_o was 0 (first error wins).
- stop_i in RUN: go to SHUT at idx = highest set bit of up_mask_o; down_req_o[idx]=1.
- stop_i in INIT/IGAP: set stop_pend. At the next completion of the current step (ack, error or timeout), go to SHUT instead of continuing.
- stop_i in IDLE, SHUT or SGAP: ignored.
- SHUT, down_ack_i[idx] high:
  - Req low; up_mask_o[idx]=0; state SGAP.
  - SGAP for one cycle, then next lower set bit of up_mask_o.
  - When up_mask_o is 0: go to IDLE with done_o=1 and stop_pend=0.
- Acks on non-requested bits are ignored. start_i is ignored unless in IDLE.
- rst_n asserted mid-operation: immediate return to reset values, with all reqs low and no teardown. The system integrator owns subsystem reset.

Optional Feature:
- Macro SUBSYS_LIFECYCLE_SEQ_TMO_EN.
- Defined: timeout counter present; behaviour as above.
- Undefined:
  - No counter; handshakes wait forever.
  - err_tmo_o tied to 0.
  - TMO_W and TMO_CYC are unused.

Test Plan:
- Happy path:
  - Stimulus: N_SUB=4, start_i, each ack one cycle after its req.
  - Required: reqs in order 0,1,2,3, each separated by one idle cycle; done_o pulses; up_o=1; up_mask_o=4'b1111.
- Reverse teardown:
  - Stimulus: stop_i from RUN.
  - Required: down_req_o order 3,2,1,0; up_mask_o steps 0111,0011,0001,0000; done_o pulses; state IDLE.
- Init error with rollback:
  - Stimulus: init_err_i[2] on its req.
  - Required: err_o=1, err_idx_o=2, err_tmo_o=0; down_req_o order 1,0; done_o pulses; IDLE. The following start_i clears err_o.
- Timeout (macro on, TMO_CYC=10):
  - Stimulus: subsystem 1 never acks init.
  - Required: req dropped after 10 cycles; err_tmo_o=1, err_idx_o=1; only subsystem 0 is torn down.
- Deferred stop:
  - Stimulus: stop_i while init_req_o[1] is high; then ack 1.
  - Required: no req for subsystem 2; teardown order 1,0.
- Async reset:
  - Stimulus: rst_n low mid-teardown.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
